divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter: XLEN, default 64, operand/result width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous and active-high (already decided); one clock domain.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 kill  input  1  pipeline flush; aborts the operation in flight.
REQ-006 DIVControl  input  3  op: div=3'b100, divu=3'b101, rem=3'b110, remu=3'b111; other codes behave as divu.
REQ-007 rs1  input  XLEN  dividend; rs2  input  XLEN  divisor; both sampled with start.
REQ-008 busy  output  1  high in DIVIDE and FINISH.
REQ-009 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-010 result  output  XLEN  quotient (div/divu) or remainder (rem/remu).

Function
REQ-011 FSM states: IDLE, DIVIDE, FINISH.
REQ-012 IDLE with start=1 and a normal case: latch magnitudes, op and signs; go to DIVIDE with the step counter at XLEN-1.
REQ-013 DIVIDE: perform one restoring shift/subtract step per cycle; after XLEN steps go to FINISH.
REQ-014 FINISH: apply sign fix-up; register result; done=1 for exactly that cycle; next state IDLE.
REQ-015 Normal latency: done asserts XLEN+1 cycles after the start edge (65 for XLEN=64).
REQ-016 Signed ops (div/rem): operate on magnitudes. Quotient is negated when the operand signs differ. Remainder takes the dividend's sign (truncating division).
REQ-017 Divide by zero (rs2=0): go IDLE->FINISH directly, done on the next cycle. Quotient = all ones for div and divu. Remainder = rs1.
REQ-018 Signed overflow (rs1=-2^(XLEN-1), rs2=-1, div/rem): fast path as REQ-017. Quotient = rs1; remainder = 0.
REQ-019 start while busy=1 is ignored; there is no queueing.
REQ-020 kill=1 in any state: next state is IDLE, no done, result unchanged. kill has priority over start in the same cycle.
REQ-021 result holds its last value until the next FINISH.
REQ-022 Back-to-back: start is accepted in the cycle after done, since the FSM is then in IDLE.

Reset
REQ-023 rst=1 at a clock edge: state IDLE, busy=0, done=0, result=0, counter=0. This includes mid-operation; rst has priority over kill and start.

Configuration
REQ-024 Macro DIV_WORD_OPS_EN defined: adds input word (1 bit). With word=1 the block uses rs1[31:0] and rs2[31:0] under the same op and signedness rules, with special cases evaluated at 32 bits. Result = 32-bit answer sign-extended to XLEN. Latency = 33 cycles.
REQ-025 Macro undefined: there is no word port and only XLEN-wide operation.

Structure
REQ-026 The package riscv_pkg holds the div_op_t enum (DIV, DIVU, REM, REMU encodings) and the XLEN default constant.
REQ-027 Sub-module div_restore_step: combinational single iteration. Inputs: partial remainder, dividend bit, divisor. Outputs: next remainder and quotient bit. It is instantiated once and reused every cycle.

Verification
REQ-028 div 100/7 -> result 14, done exactly 65 cycles after start; rem 100/7 -> 2.
REQ-029 div -100/7 -> 0xFFFFFFFFFFFFFFF2 (-14); rem -100/7 -> 0xFFFFFFFFFFFFFFFE (-2); remu 100/7 -> 2.
REQ-030 divu 5/0 -> 0xFFFFFFFFFFFFFFFF with done 1 cycle after start; rem 5/0 -> 5.
REQ-031 div 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF -> 0x8000000000000000; rem of the same operands -> 0; both 1-cycle.
REQ-032 Run divu, pulse kill at cycle 30 -> no done and busy=0 next cycle. Then divu 0xFFFFFFFFFFFFFFFF/2 -> 0x7FFFFFFFFFFFFFFF. Repeat with rst at cycle 30 -> result=0.
REQ-033 With DIV_WORD_OPS_EN: word div rs1=0x0000000080000000, rs2=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFF80000000. Word divu 0x1_0000000A / 3 -> 3, done after 33 cycles.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the iterative divider
// Contents: XLEN_DEFAULT (default operand width), div_op_t (DIVControl
// encodings), div_state_t (divider FSM states).
package riscv_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [2:0] {
        DIV  = 3'b100,
        DIVU = 3'b101,
        REM  = 3'b110,
        REMU = 3'b111
    } div_op_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_FINISH = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one combinational restoring-division iteration
// Ports:
//   rem          in   XLEN  partial remainder (always < divisor)
//   dividend_bit in   1     next dividend bit shifted in at the LSB
//   divisor      in   XLEN  divisor magnitude
//   next_rem     out  XLEN  partial remainder after the trial subtract
//   q_bit        out  1     quotient bit produced by this iteration
module div_restore_step #(
    parameter int XLEN = riscv_pkg::XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rem,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic            q_bit
);

    logic [XLEN:0] shifted;

    assign shifted = {rem, dividend_bit};
    assign q_bit   = (shifted >= {1'b0, divisor});

    // When the subtract succeeds the true difference is below the divisor,
    // so modulo-2^XLEN arithmetic on the low bits gives the exact value.
    assign next_rem = q_bit ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - multi-cycle restoring integer divider (div/divu/rem/remu)
// Optional feature macro: DIV_WORD_OPS_EN (adds 32-bit word operations).
// Ports:
//   clk         in   1     rising-edge clock
//   rst         in   1     synchronous active-high reset
//   start       in   1     operation request, sampled only in IDLE
//   kill        in   1     flush: abandon the operation in flight
//   DIVControl  in   3     op select (div/divu/rem/remu; others act as divu)
//   rs1, rs2    in   XLEN  dividend and divisor, sampled with start
//   word        in   1     (DIV_WORD_OPS_EN only) 32-bit operation select
//   busy        out  1     high while in DIVIDE or FINISH
//   done        out  1     one-cycle pulse, result valid in that cycle
//   result      out  XLEN  quotient or remainder, held until next FINISH
module divider
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      DIVControl,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
`ifdef DIV_WORD_OPS_EN
    input  logic            word,
`endif
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    div_state_t state, next_state;
    div_op_t    op;

    logic            is_signed_op;
    logic            is_rem_op;
    logic            word_mode;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic [XLEN-1:0] min_val;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] spec_res;
    logic [XLEN-1:0] quot_load;
    logic [CW-1:0]   cnt_load;

    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dsor;
    logic [CW-1:0]   cnt;
    logic            word_q;
    logic            neg_q;
    logic            neg_r;
    logic            is_rem_q;
    logic            special_q;
    logic [XLEN-1:0] spec_res_q;

    logic [XLEN-1:0] step_rem;
    logic            step_q;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] val;
    logic [XLEN-1:0] final_val;

    assign op           = div_op_t'(DIVControl);
    assign is_signed_op = (op == DIV) || (op == REM);
    assign is_rem_op    = (op == REM) || (op == REMU);

    // Operands are first brought to a common XLEN-wide form so that the
    // special-case detection and magnitude logic is shared by both widths.
`ifdef DIV_WORD_OPS_EN
    localparam int HW = XLEN - 32;

    assign word_mode = word;

    always_comb begin
        a_ext    = rs1;
        b_ext    = rs2;
        min_val  = {1'b1, {(XLEN-1){1'b0}}};
        quot_load = mag_a;
        cnt_load  = CW'(XLEN-1);
        if (word) begin
            a_ext     = {{HW{is_signed_op & rs1[31]}}, rs1[31:0]};
            b_ext     = {{HW{is_signed_op & rs2[31]}}, rs2[31:0]};
            min_val   = {{(HW+1){1'b1}}, 31'b0};
            // Magnitude sits in the top half so the MSB-first shift sees
            // only the 32 meaningful dividend bits.
            quot_load = {mag_a[31:0], {HW{1'b0}}};
            cnt_load  = CW'(31);
        end
    end

    assign final_val = word_q ? {{HW{val[31]}}, val[31:0]} : val;
`else
    assign word_mode = 1'b0;
    assign a_ext     = rs1;
    assign b_ext     = rs2;
    assign min_val   = {1'b1, {(XLEN-1){1'b0}}};
    assign quot_load = mag_a;
    assign cnt_load  = CW'(XLEN-1);
    assign final_val = val;
`endif

    assign sign_a   = is_signed_op & a_ext[XLEN-1];
    assign sign_b   = is_signed_op & b_ext[XLEN-1];
    assign mag_a    = sign_a ? (-a_ext) : a_ext;
    assign mag_b    = sign_b ? (-b_ext) : b_ext;
    assign div_zero = (b_ext == '0);
    assign overflow = is_signed_op && (a_ext == min_val) && (b_ext == '1);
    assign special  = div_zero | overflow;

    // Divide by zero: quotient all ones, remainder = dividend.
    // Signed overflow: quotient = dividend, remainder = 0.
    always_comb begin
        spec_res = '0;
        if (div_zero) begin
            spec_res = is_rem_op ? a_ext : '1;
        end else begin
            spec_res = is_rem_op ? '0 : a_ext;
        end
    end

    div_restore_step #(.XLEN(XLEN)) u_step (
        .rem          (rem_q),
        .dividend_bit (quot[XLEN-1]),
        .divisor      (dsor),
        .next_rem     (step_rem),
        .q_bit        (step_q)
    );

    assign q_fix = neg_q ? (-quot)  : quot;
    assign r_fix = neg_r ? (-rem_q) : rem_q;
    assign val   = special_q ? spec_res_q : (is_rem_q ? r_fix : q_fix);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM: next-state logic; kill overrides everything but reset
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = special ? S_FINISH : S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (cnt == '0) begin
                    next_state = S_FINISH;
                end
            end
            S_FINISH: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
        if (kill) begin
            next_state = S_IDLE;
        end
    end

    // FSM: outputs
    always_comb begin
        busy = 1'b0;
        if (state == S_DIVIDE || state == S_FINISH) begin
            busy = 1'b1;
        end
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            quot       <= '0;
            rem_q      <= '0;
            dsor       <= '0;
            cnt        <= '0;
            word_q     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            is_rem_q   <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            result     <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !kill) begin
                        quot       <= quot_load;
                        rem_q      <= '0;
                        dsor       <= mag_b;
                        cnt        <= cnt_load;
                        word_q     <= word_mode;
                        neg_q      <= sign_a ^ sign_b;
                        neg_r      <= sign_a;
                        is_rem_q   <= is_rem_op;
                        special_q  <= special;
                        spec_res_q <= spec_res;
                    end
                end
                S_DIVIDE: begin
                    quot  <= {quot[XLEN-2:0], step_q};
                    rem_q <= step_rem;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FINISH: begin
                    if (!kill) begin
                        result <= final_val;
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed self-checking bench for divider
module tb_divider;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            kill;
    logic [2:0]      DIVControl;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
`ifdef DIV_WORD_OPS_EN
    logic            word;
`endif
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t0     = 0;
    int lat;
    int done_cnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    divider #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .kill       (kill),
        .DIVControl (DIVControl),
        .rs1        (rs1),
        .rs2        (rs2),
`ifdef DIV_WORD_OPS_EN
        .word       (word),
`endif
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        DIVControl = op;
        rs1        = a;
        rs2        = b;
        start      = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                l = cyc - t0;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
        int l;
        launch(op, a, b);
        wait_done(l);
        check({tag, "_result"}, result, exp);
        check({tag, "_latency"}, 64'(l), 64'(exp_lat));
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        kill       = 1'b0;
        DIVControl = 3'b100;
        rs1        = '0;
        rs2        = '0;
`ifdef DIV_WORD_OPS_EN
        word       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", result, 64'd0);

        run("div_100_7",    3'b100, 64'd100, 64'd7, 64'd14, 65);
        run("rem_100_7",    3'b110, 64'd100, 64'd7, 64'd2, 65);
        run("div_m100_7",   3'b100, 64'hFFFFFFFFFFFFFF9C, 64'd7, 64'hFFFFFFFFFFFFFFF2, 65);
        run("rem_m100_7",   3'b110, 64'hFFFFFFFFFFFFFF9C, 64'd7, 64'hFFFFFFFFFFFFFFFE, 65);
        run("remu_100_7",   3'b111, 64'd100, 64'd7, 64'd2, 65);
        run("divu_5_0",     3'b101, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1);
        run("rem_5_0",      3'b110, 64'd5, 64'd0, 64'd5, 1);
        run("div_ovf",      3'b100, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1);
        run("rem_ovf",      3'b110, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1);
        run("op000_divu",   3'b000, 64'hFFFFFFFFFFFFFFFE, 64'd2, 64'h7FFFFFFFFFFFFFFF, 65);
        run("divu_1000_10", 3'b101, 64'd1000, 64'd10, 64'd100, 65);

        // A start pulse mid-operation must not disturb the running divide.
        launch(3'b100, 64'd100, 64'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rs1   = 64'd50;
        rs2   = 64'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        check("busy_start_result", result, 64'd14);
        check("busy_start_latency", 64'(lat), 64'd65);

        run("divu_1000_10b", 3'b101, 64'd1000, 64'd10, 64'd100, 65);

        // Kill at cycle 30 of a divu.
        launch(3'b101, 64'd12345, 64'd3);
        repeat (29) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_busy", 64'(busy), 64'd0);
        check("kill_done", 64'(done), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("kill_no_done", 64'(done_cnt), 64'd0);
        check("kill_result_held", result, 64'd100);

        run("divu_max_2", 3'b101, 64'hFFFFFFFFFFFFFFFF, 64'd2, 64'h7FFFFFFFFFFFFFFF, 65);

        // Reset at cycle 30 of a divu.
        launch(3'b101, 64'd12345, 64'd3);
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_result", result, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);

`ifdef DIV_WORD_OPS_EN
        word = 1'b1;
        run("w_div_ovf",  3'b100, 64'h0000000080000000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 1);
        run("w_divu_10_3", 3'b101, 64'h000000010000000A, 64'd3, 64'd3, 33);
        word = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
